ad9122_spi_txn_engine: RTL and testbench

//  Bit-level SPI master for the AD9122 config path; sits directly downstream of the register-sequence FSM.

---
 rtl/ad9122_spi_txn_engine.sv | 161 ++++++++++++++++
 tb/tb_ad9122_spi_txn_engine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9122_spi_txn_engine.sv
// rtl/ad9122_spi_txn_engine.sv - bit-level SPI master executing write/read/delay transactions for the AD9122
module ad9122_spi_txn_engine #(
    parameter int SPI_INFO_LENGTH = 8,
    parameter int SPI_DATA_LENGTH = 8,
    parameter int CLK_DIV         = 4,
    parameter int CS_SETUP        = 2,
    parameter int CS_HOLD         = 2,
    parameter int GAP_CYCLES      = 4,
    parameter int DELAY_UNIT      = 1000
) (
    input  logic                                       clk_in,
    input  logic                                       rst,
    input  logic [1:0]                                 i_wrrd_mode_sel,
    input  logic [SPI_INFO_LENGTH+SPI_DATA_LENGTH-1:0] i_wr_infodata,
    input  logic [SPI_INFO_LENGTH-1:0]                 i_rd_info,
    input  logic [15:0]                                i_delay_cnt,
    input  logic                                       datain_valid,
    output logic                                       datain_ready,
    output logic [SPI_DATA_LENGTH-1:0]                 o_rd_data,
    output logic                                       o_sclk,
    output logic                                       o_sda,
    output logic                                       o_sda_dir,
    input  logic                                       i_sda,
    output logic                                       o_cs_n
);

    localparam int TOTAL_BITS = SPI_INFO_LENGTH + SPI_DATA_LENGTH;
    localparam int BIT_W      = $clog2(TOTAL_BITS);
    localparam int DIV_W      = $clog2(2 * CLK_DIV);
    localparam logic [1:0] MODE_WR  = 2'b00;
    localparam logic [1:0] MODE_RD  = 2'b01;
    localparam logic [1:0] MODE_DLY = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_CS_SETUP, S_SHIFT_INFO, S_SHIFT_DATA,
        S_RD_DATA, S_CS_HOLD, S_DELAY, S_DONE, S_GAP
    } state_t;

    state_t                     state, state_nxt;
    logic [1:0]                 mode_q;
    logic [TOTAL_BITS-1:0]      tx_shift;
    logic [SPI_DATA_LENGTH-1:0] rx_shift;
    logic [31:0]                dly_rem;
    logic [15:0]                cyc_cnt;
    logic [DIV_W-1:0]           div_cnt;
    logic [BIT_W-1:0]           bit_cnt;
    logic                       shifting, bit_end, info_end, last_bit, rise_cyc, sclk_hi;

    // Each bit spans 2*CLK_DIV cycles: low half first, so SDIO settles before the rising edge.
    assign shifting = (state == S_SHIFT_INFO) || (state == S_SHIFT_DATA) || (state == S_RD_DATA);
    assign bit_end  = div_cnt == DIV_W'(2 * CLK_DIV - 1);
    assign rise_cyc = div_cnt == DIV_W'(CLK_DIV);
    assign sclk_hi  = div_cnt >= DIV_W'(CLK_DIV);
    assign info_end = bit_end && (bit_cnt == BIT_W'(SPI_INFO_LENGTH - 1));
    assign last_bit = bit_end && (bit_cnt == BIT_W'(TOTAL_BITS - 1));

    always_comb begin
        state_nxt    = state;
        o_cs_n       = 1'b1;
        o_sclk       = 1'b0;
        o_sda        = 1'b0;
        o_sda_dir    = 1'b1;
        datain_ready = 1'b0;
        case (state)
            S_IDLE:       if (datain_valid) state_nxt = S_LATCH;
            S_LATCH: begin
                case (i_wrrd_mode_sel)
                    MODE_WR, MODE_RD: state_nxt = S_CS_SETUP;
                    MODE_DLY:         state_nxt = S_DELAY;
                    default:          state_nxt = S_DONE;
                endcase
            end
            S_CS_SETUP: begin
                o_cs_n = 1'b0;
                o_sda  = tx_shift[TOTAL_BITS-1];
                if (cyc_cnt == 16'(CS_SETUP - 1)) state_nxt = S_SHIFT_INFO;
            end
            S_SHIFT_INFO: begin
                o_cs_n = 1'b0;
                o_sclk = sclk_hi;
                o_sda  = tx_shift[TOTAL_BITS-1];
                if (info_end) state_nxt = (mode_q == MODE_RD) ? S_RD_DATA : S_SHIFT_DATA;
            end
            S_SHIFT_DATA: begin
                o_cs_n = 1'b0;
                o_sclk = sclk_hi;
                o_sda  = tx_shift[TOTAL_BITS-1];
                if (last_bit) state_nxt = S_CS_HOLD;
            end
            S_RD_DATA: begin
                o_cs_n    = 1'b0;
                o_sclk    = sclk_hi;
                o_sda_dir = 1'b0;
                if (last_bit) state_nxt = S_CS_HOLD;
            end
            S_CS_HOLD: begin
                o_cs_n    = 1'b0;
                o_sda_dir = (mode_q != MODE_RD);
                if (cyc_cnt == 16'(CS_HOLD - 1)) state_nxt = S_DONE;
            end
            S_DELAY:      if (dly_rem <= 32'd1) state_nxt = S_DONE;
            S_DONE: begin
                datain_ready = 1'b1;
                state_nxt    = S_GAP;
            end
            S_GAP:        if (cyc_cnt == 16'(GAP_CYCLES - 1)) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_q    <= 2'b00;
            tx_shift  <= '0;
            rx_shift  <= '0;
            dly_rem   <= '0;
            cyc_cnt   <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            o_rd_data <= '0;
        end else begin
            state <= state_nxt;
            if ((state_nxt == state) &&
                ((state == S_CS_SETUP) || (state == S_CS_HOLD) || (state == S_GAP)))
                cyc_cnt <= cyc_cnt + 1'b1;
            else
                cyc_cnt <= '0;

            // Request fields are frozen here; the sequencer may change inputs afterwards.
            if (state == S_LATCH) begin
                mode_q   <= i_wrrd_mode_sel;
                tx_shift <= (i_wrrd_mode_sel == MODE_RD) ?
                            {i_rd_info, {SPI_DATA_LENGTH{1'b0}}} : i_wr_infodata;
                dly_rem  <= 32'(i_delay_cnt) * 32'(DELAY_UNIT);
            end

            if ((state == S_DELAY) && (dly_rem != 32'd0))
                dly_rem <= dly_rem - 1'b1;

            if (shifting) begin
                if (bit_end) begin
                    div_cnt  <= '0;
                    bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
                    tx_shift <= tx_shift << 1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                if ((state == S_RD_DATA) && rise_cyc)
                    rx_shift <= {rx_shift[SPI_DATA_LENGTH-2:0], i_sda};
            end else begin
                div_cnt <= '0;
                bit_cnt <= '0;
            end

            if ((state == S_DONE) && (mode_q == MODE_RD))
                o_rd_data <= rx_shift;
        end
    end

endmodule

// File: tb/tb_ad9122_spi_txn_engine.sv
// tb/tb_ad9122_spi_txn_engine.sv - scoreboard bench for ad9122_spi_txn_engine against a transaction-level model
module tb_ad9122_spi_txn_engine;

    localparam int CLK_DIV    = 4;
    localparam int CS_SETUP   = 2;
    localparam int CS_HOLD    = 2;
    localparam int GAP_CYCLES = 4;
    localparam int DELAY_UNIT = 1000;
    localparam int BUS_CS_LOW = CS_SETUP + 32 * CLK_DIV + CS_HOLD;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  i_wrrd_mode_sel = 2'b00;
    logic [15:0] i_wr_infodata = 16'h0;
    logic [7:0]  i_rd_info = 8'h0;
    logic [15:0] i_delay_cnt = 16'h0;
    logic        datain_valid = 1'b0;
    logic        datain_ready;
    logic [7:0]  o_rd_data;
    logic        o_sclk, o_sda, o_sda_dir, o_cs_n;
    logic        i_sda = 1'b0;

    always #5 clk_in = ~clk_in;

    ad9122_spi_txn_engine #(
        .SPI_INFO_LENGTH(8), .SPI_DATA_LENGTH(8), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .GAP_CYCLES(GAP_CYCLES), .DELAY_UNIT(DELAY_UNIT)
    ) dut (
        .clk_in(clk_in), .rst(rst), .i_wrrd_mode_sel(i_wrrd_mode_sel),
        .i_wr_infodata(i_wr_infodata), .i_rd_info(i_rd_info), .i_delay_cnt(i_delay_cnt),
        .datain_valid(datain_valid), .datain_ready(datain_ready), .o_rd_data(o_rd_data),
        .o_sclk(o_sclk), .o_sda(o_sda), .o_sda_dir(o_sda_dir), .i_sda(i_sda), .o_cs_n(o_cs_n)
    );

    typedef struct {
        int          cs_low;
        int          rises;
        int          drv;
        logic [15:0] word;
        int          dir_at;
        logic [7:0]  rd;
        int          t0;
        int          lat_lo;
        int          lat_hi;
    } exp_t;

    exp_t       exp_q[$];
    int         nvec = 0, nerr = 0, cyc = 0, tmo_cnt = 0;
    bit         end_req = 1'b0;
    logic [7:0] ref_mem[128];
    logic [7:0] last_rd = 8'h00;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [7:0] mem_init(input int i);
        return 8'((i * 29) ^ 90);
    endfunction

    // Transaction-level reference: what the bus and the sequencer should see for one request.
    function automatic exp_t model(input logic [1:0] m, input logic [15:0] w,
                                   input logic [7:0] ri, input logic [15:0] dc);
        exp_t e;
        e.cs_low = 0; e.rises = 0; e.drv = 0; e.word = 16'h0; e.dir_at = -1;
        e.t0 = -1; e.lat_lo = 0; e.lat_hi = 3;
        case (m)
            2'b00: begin
                e.cs_low = BUS_CS_LOW; e.rises = 16; e.drv = 16; e.word = w;
                ref_mem[w[14:8]] = w[7:0];
            end
            2'b01: begin
                e.cs_low = BUS_CS_LOW; e.rises = 16; e.drv = 8; e.word = {8'h00, ri};
                e.dir_at = 8;
                last_rd = ref_mem[ri[6:0]];
            end
            2'b10: begin
                e.lat_lo = int'(dc) * DELAY_UNIT;
                e.lat_hi = e.lat_lo + 3;
            end
            default: ;
        endcase
        e.rd = last_rd;
        return e;
    endfunction

    task automatic chk(input string nm, input longint act, input longint expv);
        nvec++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, expv);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
        nvec++;
        if (act < lo || act > hi) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Slave: register file on the 3-wire bus; read data launched on SCLK falling edges.
    logic [7:0]  slave_mem[128];
    logic [15:0] s_word = 16'h0;
    logic [7:0]  s_byte;
    int          s_bits = 0, s_falls = 0;
    logic        s_prev = 1'b0;
    bit          s_init = 1'b0;

    always @(negedge clk_in) begin
        if (!s_init) begin
            for (int i = 0; i < 128; i++) slave_mem[i] = mem_init(i);
            s_init = 1'b1;
        end
        if (o_cs_n) begin
            s_bits = 0;
            s_falls = 0;
        end else begin
            if (o_sclk && !s_prev && o_sda_dir) begin
                s_word = {s_word[14:0], o_sda};
                s_bits++;
                if (s_bits == 16 && !s_word[15]) slave_mem[s_word[14:8]] = s_word[7:0];
            end
            if (!o_sclk && s_prev) begin
                s_falls++;
                if (s_falls >= 8 && s_falls < 16 && s_bits == 8 && s_word[7]) begin
                    s_byte = slave_mem[s_word[6:0]];
                    i_sda = s_byte[15 - s_falls];
                end
            end
        end
        s_prev = o_sclk;
    end

    // Monitor: gathers bus statistics and checks them against the scoreboard at each ready pulse.
    int          m_cs_low = 0, m_rises = 0, m_drv = 0, m_dir_at = -1, m_hi = 0;
    logic [15:0] m_cap = 16'h0;
    logic        m_prev_sclk = 1'b0, m_prev_cs = 1'b1, m_seen_rise = 1'b0, rd_pend = 1'b0;
    logic [7:0]  pend_rd = 8'h0;
    exp_t        e_mon;

    always @(negedge clk_in) begin
        if (rst) begin
            chk("rst_cs_n", o_cs_n, 1);
            chk("rst_sclk", o_sclk, 0);
            chk("rst_sda", o_sda, 0);
            chk("rst_sda_dir", o_sda_dir, 1);
            chk("rst_ready", datain_ready, 0);
            chk("rst_rd_data", o_rd_data, 0);
            m_cs_low = 0; m_rises = 0; m_drv = 0; m_dir_at = -1; m_cap = 16'h0; m_hi = 0;
            m_prev_sclk = 1'b0; m_prev_cs = 1'b1; rd_pend = 1'b0;
        end else begin
            if (rd_pend) begin
                chk("rd_data", o_rd_data, pend_rd);
                rd_pend = 1'b0;
            end
            if (!o_cs_n) m_cs_low++;
            if (o_cs_n) begin
                if (!m_prev_cs) begin m_hi = 0; m_seen_rise = 1'b1; end
                m_hi++;
            end else if (m_prev_cs && m_seen_rise) begin
                chk_rng("cs_gap", m_hi, GAP_CYCLES, 1000000000);
            end
            if (o_sclk && !m_prev_sclk) begin
                m_rises++;
                if (!o_cs_n && o_sda_dir) begin
                    m_cap = {m_cap[14:0], o_sda};
                    m_drv++;
                end
            end
            if (!o_sda_dir && m_dir_at < 0) m_dir_at = m_rises;
            m_prev_sclk = o_sclk;
            m_prev_cs = o_cs_n;
            if (datain_ready) begin
                chk_rng("ready_expected", exp_q.size(), 1, 1000);
                if (exp_q.size() > 0) begin
                    e_mon = exp_q.pop_front();
                    chk("cs_low_cycles", m_cs_low, e_mon.cs_low);
                    chk("sclk_rises", m_rises, e_mon.rises);
                    chk("driven_bits", m_drv, e_mon.drv);
                    chk("sdio_word", m_cap, e_mon.word);
                    chk("dir_fall_rise", m_dir_at, e_mon.dir_at);
                    if (e_mon.t0 >= 0)
                        chk_rng("latency", cyc - e_mon.t0 - 1, e_mon.lat_lo, e_mon.lat_hi);
                    rd_pend = 1'b1;
                    pend_rd = e_mon.rd;
                end
                m_cs_low = 0; m_rises = 0; m_drv = 0; m_dir_at = -1; m_cap = 16'h0;
            end
        end
        if (end_req || cyc > 90000) begin
            if (!end_req) begin
                nerr++;
                $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
            end
            chk("driver_timeouts", tmo_cnt, 0);
            chk("queue_left", exp_q.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
            $finish;
        end
    end

    task automatic scramble();
        i_wrrd_mode_sel = 2'($urandom);
        i_wr_infodata = 16'($urandom);
        i_rd_info = 8'($urandom);
        i_delay_cnt = 16'($urandom);
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 10000; i++) begin
            if (datain_ready) break;
            @(negedge clk_in);
        end
        if (i == 10000) tmo_cnt++;
    endtask

    task automatic wait_cs(input logic lvl);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (o_cs_n == lvl) break;
            @(negedge clk_in);
        end
        if (i == 2000) tmo_cnt++;
    endtask

    task automatic run_txn(input logic [1:0] m, input logic [15:0] w,
                           input logic [7:0] ri, input logic [15:0] dc);
        exp_t e;
        @(negedge clk_in); #1;
        e = model(m, w, ri, dc);
        e.t0 = m[1] ? cyc : -1;
        exp_q.push_back(e);
        i_wrrd_mode_sel = m; i_wr_infodata = w; i_rd_info = ri; i_delay_cnt = dc;
        datain_valid = 1'b1;
        repeat (2) @(negedge clk_in); #1;
        datain_valid = 1'b0;
        scramble();
        wait_ready();
        repeat (GAP_CYCLES + 2) @(negedge clk_in);
    endtask

    task automatic back_to_back();
        logic [15:0] w;
        exp_t e;
        @(negedge clk_in); #1;
        w = {1'b0, 15'($urandom)};
        exp_q.push_back(model(2'b00, w, 8'h00, 16'h0));
        i_wrrd_mode_sel = 2'b00; i_wr_infodata = w; datain_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_cs(1'b0);
            repeat (20) @(negedge clk_in); #1;
            scramble();
            repeat (20) @(negedge clk_in); #1;
            if (k < 2) begin
                w = {1'b0, 15'($urandom)};
                e = model(2'b00, w, 8'h00, 16'h0);
                exp_q.push_back(e);
                i_wrrd_mode_sel = 2'b00; i_wr_infodata = w;
            end else begin
                datain_valid = 1'b0;
            end
            wait_cs(1'b1);
        end
        repeat (GAP_CYCLES + 4) @(negedge clk_in);
    endtask

    task automatic reset_mid_write();
        int   r;
        logic p;
        r = 0; p = 1'b0;
        @(negedge clk_in); #1;
        i_wrrd_mode_sel = 2'b00; i_wr_infodata = 16'h3C5A; datain_valid = 1'b1;
        for (int i = 0; i < 500 && r < 6; i++) begin
            @(negedge clk_in);
            if (o_sclk && !p) r++;
            p = o_sclk;
        end
        if (r < 6) tmo_cnt++;
        #1;
        rst = 1'b1; datain_valid = 1'b0; last_rd = 8'h00;
        repeat (3) @(negedge clk_in); #1;
        rst = 1'b0;
        repeat (30) @(negedge clk_in);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = mem_init(i);
        repeat (4) @(negedge clk_in); #1;
        rst = 1'b0;
        run_txn(2'b00, 16'h00A0, 8'h00, 16'd0);
        run_txn(2'b00, 16'h1807, 8'h00, 16'd0);
        run_txn(2'b01, 16'h0000, 8'h98, 16'd0);
        run_txn(2'b10, 16'h0000, 8'h00, 16'd4);
        run_txn(2'b11, 16'h0000, 8'h00, 16'd0);
        run_txn(2'b10, 16'h0000, 8'h00, 16'd0);
        run_txn(2'b01, 16'h0000, 8'h85, 16'd0);
        back_to_back();
        reset_mid_write();
        run_txn(2'b01, 16'h0000, 8'h98, 16'd0);
        for (int k = 0; k < 30; k++)
            run_txn(2'($urandom_range(0, 3)), {1'b0, 15'($urandom)},
                    {1'b1, 7'($urandom)}, 16'($urandom_range(0, 2)));
        repeat (5) @(negedge clk_in);
        end_req = 1'b1;
        repeat (20) @(negedge clk_in);
    end

endmodule
